// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult: iterative radix-4 Booth multiplier, signed N x N -> 2N.
// One Booth digit is encoded and accumulated per RUN cycle; valid/ready on both sides.
//
// Parameters:
//   N      operand width (even, >= 4)
//   CNT_W  digit counter width
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (a, b sampled on acceptance)
//   out_valid / out_ready product handshake
//   a, b                  multiplicand, multiplier
//   product               2N-bit result, valid while out_valid
//   pp_mon                partial product selected this cycle (debug, 0 outside RUN)
//   busy                  high while digits are being processed
//
// Optional build macro BOOTH_UNSIGNED_MODE_EN adds input is_unsigned:
//   when set at acceptance the operands are zero-extended and one extra
//   digit is processed so the result is the unsigned 2N-bit product.

module booth_radix4_seq_mult #(
   parameter int N     = 32,
   parameter int CNT_W = $clog2(N/2+2)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic [N+2:0]   pp_mon,
   output logic           busy
`ifdef BOOTH_UNSIGNED_MODE_EN
   ,
   input  logic           is_unsigned
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_S = CNT_W'(N/2-1);
   localparam logic [CNT_W-1:0] LAST_U = CNT_W'(N/2);

   state_t state_q;
   state_t state_d;

   logic [N+1:0]   a_q;
   logic [N+1:0]   m_q;
   logic [2*N+1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic           uns_q;
   logic           uns_in;

   logic           accept;
   logic           run;
   logic           last_dig;
   logic [CNT_W-1:0] last_cnt;

   logic [2:0]     t;
   logic           single;
   logic           dbl;
   logic           neg;
   logic [N+2:0]   sel;
   logic [N+2:0]   pp;
   logic [2*N+1:0] addend;
   logic [1:0]     acc_unused;

`ifdef BOOTH_UNSIGNED_MODE_EN
   assign uns_in = is_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   // Extension bit for both operands at acceptance.
   logic ext_a;
   logic ext_b;
   assign ext_a = uns_in ? 1'b0 : a[N-1];
   assign ext_b = uns_in ? 1'b0 : b[N-1];

   assign accept   = in_valid && (state_q == IDLE);
   assign run      = (state_q == RUN);
   assign last_cnt = uns_q ? LAST_U : LAST_S;
   assign last_dig = (cnt_q == last_cnt);

   // Booth digit encoder
   assign t      = m_q[2:0];
   assign single = t[1] ^ t[0];
   assign dbl    = (t[2] & ~t[1] & ~t[0]) | (~t[2] & t[1] & t[0]);
   assign neg    = t[2];

   // Selector: magnitude is A or 2A; negation is ~sel plus a carry-in of 1
   always_comb begin
      sel = '0;
      if (dbl)
         sel = sel | {a_q, 1'b0};
      if (single)
         sel = sel | {a_q[N+1], a_q};
      pp = neg ? ~sel : sel;
   end

   // Sign-extend PP, add the negation carry, weight by 4^count
   assign addend = ({{(N-1){pp[N+2]}}, pp}
                    + {{(2*N+1){1'b0}}, neg})
                   << {cnt_q, 1'b0};

   // Top two accumulator bits only absorb overflow of the modular sum
   assign acc_unused = acc_q[2*N+1:2*N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_dig)
               state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         m_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         uns_q <= 1'b0;
      end else if (accept) begin
         a_q   <= {ext_a, ext_a, a};
         m_q   <= {ext_b, b, 1'b0};
         acc_q <= '0;
         cnt_q <= '0;
         uns_q <= uns_in;
      end else if (run) begin
         acc_q <= acc_q + addend;
         m_q   <= {m_q[N+1], m_q[N+1], m_q[N+1:2]};
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign pp_mon  = run ? pp : '0;
   assign product = (state_q == DONE) ? acc_q[2*N-1:0] : '0;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// tb_booth_radix4_seq_mult: directed + random checks of the Booth multiplier
// against plain integer multiplication.

module tb_booth_radix4_seq_mult;

   localparam int N = 32;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a_i;
   logic [N-1:0]   b_i;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;
   logic [N+2:0]   pp_mon;
   logic           busy;
   logic           uns;

   int checks;
   int errors;

   booth_radix4_seq_mult #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .pp_mon    (pp_mon),
      .busy      (busy)
`ifdef BOOTH_UNSIGNED_MODE_EN
      ,
      .is_unsigned (uns)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic u);
      longint sx;
      longint sy;
      sx = u ? longint'(x) : longint'($signed(x));
      sy = u ? longint'(y) : longint'($signed(y));
      return 64'(sx * sy);
   endfunction

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic run_op(input logic [31:0] x,
                         input logic [31:0] y,
                         input logic u,
                         input int hold,
                         input logic chk_nz,
                         input string tag);
      int n;
      int iter;
      logic saw;
      logic [63:0] exp;
      exp  = ref_mul(x, y, u);
      iter = u ? N/2 + 1 : N/2;
      @(negedge clk);
      a_i = x;
      b_i = y;
      uns = u;
      in_valid = 1'b1;
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_i = $urandom;
      b_i = $urandom;
      uns = $urandom_range(0, 1);
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      n = 0;
      saw = 1'b0;
      while (!out_valid && n < 100) begin
         if (pp_mon != '0)
            saw = 1'b1;
         in_valid = $urandom_range(0, 1);
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, 64'(n), 64'(iter));
      chk({tag, ".product"}, product, exp);
      chk({tag, ".pp_idle"}, 64'(pp_mon), 64'd0);
      chk({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
      if (chk_nz)
         chk({tag, ".pp_seen"}, 64'(saw), 64'd1);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk({tag, ".hold_prod"}, product, exp);
         chk({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
      end
      // in_valid stays high across handoff; it must not be taken
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, ".ov_clear"}, 64'(out_valid), 64'd0);
      chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
      chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_i       = '0;
      b_i       = '0;
      uns       = 1'b0;

      #12;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.product", product, 64'd0);
      chk("rst.pp_mon", 64'(pp_mon), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(32'd10, 32'd3, 1'b0, 0, 1'b1, "d10x3");
      run_op(-32'sd7, 32'd5, 1'b0, 0, 1'b0, "dm7x5");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, "dm1xm1");
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, 1'b0, "dminmin");
      run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 10, 1'b0, "dmaxmin");

      for (int k = 0; k < 20; k++)
         run_op($urandom, $urandom, 1'b0, $urandom_range(0, 3), 1'b0, "rnd");

      // reset in the middle of digit 7
      @(negedge clk);
      a_i = 32'd123;
      b_i = 32'd456;
      uns = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mrst.in_ready", 64'(in_ready), 64'd1);
      chk("mrst.out_valid", 64'(out_valid), 64'd0);
      chk("mrst.busy", 64'(busy), 64'd0);
      chk("mrst.product", product, 64'd0);
      chk("mrst.pp_mon", 64'(pp_mon), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd6, 32'd7, 1'b0, 0, 1'b0, "d6x7");

`ifdef BOOTH_UNSIGNED_MODE_EN
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, "uffxff");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, "sffxff");
      for (int k = 0; k < 10; k++)
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'b0, "rndu");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
